// File: rtl/acq_sequencer_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding and
// timing constants used by the RTL and by benches that predict capture length.
package acq_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    DELAY,
    CAPTURE,
    GAP,
    DONE
  } state_e;

  localparam int DEF_TIMEOUT = 16384;
  localparam int CAPTURE_LEN = 8192;

  // Reload value for the length counter: a zero pulse length still fires one cycle.
  function automatic logic [7:0] pulse_m1(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Control/status and ADC handshake bundle between the register block,
// the sequencer and the ADC capture block.
interface acq_sequencer_if #(
  parameter int CNT_W = 24
);
  logic             arm;
  logic             abort;
  logic [7:0]       cfg_num_acq;
  logic [7:0]       cfg_pulse_len;
  logic [15:0]      cfg_delay;
  logic [CNT_W-1:0] cfg_period;
  logic             adc_finish;
  logic             pulse_out;
  logic             adc_start;
  logic             busy;
  logic [7:0]       acq_idx;
  logic             done;
  logic             err_timeout;

  modport master (
    output arm, abort, cfg_num_acq, cfg_pulse_len, cfg_delay, cfg_period, adc_finish,
    input  pulse_out, adc_start, busy, acq_idx, done, err_timeout
  );

  modport slave (
    input  arm, abort, cfg_num_acq, cfg_pulse_len, cfg_delay, cfg_period, adc_finish,
    output pulse_out, adc_start, busy, acq_idx, done, err_timeout
  );
endinterface

// File: rtl/acq_down_counter.sv
// Loadable down-counter with zero flag; times the PULSE and DELAY phases.
module acq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)                 cnt <= '0;
    else if (load)                cnt <= val;
    else if (en && cnt != '0)     cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/acq_sequencer.sv
// Ultrasound acquisition burst sequencer: pulse, delay, capture, gap, repeated
// at a fixed pulse-repetition period for the programmed number of shots.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            reset_n,
  acq_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, state_nx;
  logic [7:0]       num_q, len_q, idx_q;
  logic [15:0]      dly_q, dc_val;
  logic [CNT_W-1:0] per_q, per_cnt, cap_cnt;
  logic [CNT_W:0]   per_nxt;
  logic             gap_ok, per_ok, arm_ok, tmo, dc_load, dc_en, dc_zero, enter_pulse;
  logic             err_q, pulse_q, start_q, busy_q, done_q;

  assign arm_ok  = bus.arm && !bus.abort && (bus.cfg_num_acq != 8'd0);
  assign tmo     = (state == CAPTURE) && !bus.adc_finish && (cap_cnt == TMO_LAST);
  // One extra bit so cfg_period = 0 and a saturated counter compare cleanly.
  assign per_nxt = {1'b0, per_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign per_ok  = per_nxt >= {1'b0, per_q};
  assign dc_en   = (state == PULSE) || (state == DELAY);
  assign enter_pulse = (state_nx == PULSE) && (state != PULSE);

  always_comb begin
    state_nx = state;
    dc_load  = 1'b0;
    dc_val   = '0;
    case (state)
      IDLE: if (arm_ok) begin
        state_nx = PULSE;
        dc_load  = 1'b1;
        dc_val   = {8'd0, pulse_m1(bus.cfg_pulse_len)};
      end
      PULSE: if (dc_zero) begin
        if (dly_q == 16'd0) state_nx = CAPTURE;
        else begin
          state_nx = DELAY;
          dc_load  = 1'b1;
          dc_val   = dly_q - 16'd1;
        end
      end
      DELAY:   if (dc_zero) state_nx = CAPTURE;
      CAPTURE: if (bus.adc_finish) state_nx = GAP;
               else if (tmo)       state_nx = IDLE;
      GAP: if (gap_ok && per_ok) begin
        if (idx_q == num_q) state_nx = DONE;
        else begin
          state_nx = PULSE;
          dc_load  = 1'b1;
          dc_val   = {8'd0, pulse_m1(len_q)};
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) begin
      state_nx = IDLE;
      dc_load  = 1'b0;
    end
  end

  acq_down_counter #(.W(16)) u_len_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (dc_load),
    .en      (dc_en),
    .val     (dc_val),
    .zero    (dc_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      num_q   <= '0;
      len_q   <= '0;
      dly_q   <= '0;
      per_q   <= '0;
      per_cnt <= '0;
      cap_cnt <= '0;
      gap_ok  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && arm_ok) begin
        num_q <= bus.cfg_num_acq;
        len_q <= bus.cfg_pulse_len;
        dly_q <= bus.cfg_delay;
        per_q <= bus.cfg_period;
        idx_q <= '0;
        err_q <= 1'b0;
      end
      if (state == CAPTURE && bus.adc_finish && !bus.abort) idx_q <= idx_q + 8'd1;
      if (tmo && !bus.abort) err_q <= 1'b1;
      if (enter_pulse)            per_cnt <= '0;
      else if (per_cnt != '1)     per_cnt <= per_cnt + CNT_W'(1);
      cap_cnt <= (state == CAPTURE) ? cap_cnt + CNT_W'(1) : '0;
      // High only on the second and later GAP cycles: enforces the 2-cycle gap.
      gap_ok  <= (state == GAP);
      pulse_q <= (state_nx == PULSE);
      start_q <= (state_nx == CAPTURE);
      busy_q  <= (state_nx != IDLE);
      done_q  <= (state_nx == DONE);
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.adc_start   = start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.acq_idx     = idx_q;
  assign bus.err_timeout = err_q;
endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Sequences one ultrasound acquisition burst: fires the transmit pulse, waits a programmable delay, starts the ADC capture block and waits for its `finish`, and repeats at a fixed pulse-repetition period for a programmed number of shots. It sits between the register/control interface and the ADC capture block.

## Interface
- `CNT_W`, 24: width of the period and timeout counters.
- `TIMEOUT`, 16384: maximum number of cycles in CAPTURE before the block declares an error.
- `clk` in 1: system clock, the same clock as ADC capture.
- `reset_n` in 1: **synchronous, active-low** reset.
- `arm` in 1: one-cycle start request.
- `abort` in 1: stop immediately. Level-sensitive.
- `cfg_num_acq` in 8: number of shots. 0 means arm is ignored.
- `cfg_pulse_len` in 8: transmit pulse width in cycles. 0 is treated as 1.
- `cfg_delay` in 16: cycles from the end of the pulse to `adc_start`.
- `cfg_period` in CNT_W: shot-to-shot period in cycles, measured from one PULSE entry to the next.
- `adc_finish` in 1: end-of-capture pulse from ADC capture.
- `pulse_out` out 1: transmit pulse.
- `adc_start` out 1: capture request, held high until `adc_finish`.
- `busy` out 1: high in every state except IDLE.
- `acq_idx` out 8: number of completed shots in the current burst.
- `done` out 1: one-cycle pulse when the burst completes normally.
- `err_timeout` out 1: sticky; cleared by an accepted `arm`.

## Operation
- States: IDLE, PULSE, DELAY, CAPTURE, GAP, DONE.
- **IDLE**
  - `arm` with `cfg_num_acq`≠0: latch all `cfg_*` inputs, clear `acq_idx` and `err_timeout`, go to PULSE.
  - `cfg_*` changes after `arm` have no effect until the next `arm`.
- **PULSE**
  - `pulse_out`=1 for exactly max(`cfg_pulse_len`,1) cycles.
  - The period counter restarts at 0 on entry.
  - Then go to DELAY, or to CAPTURE directly if `cfg_delay`=0.
- **DELAY**: lasts exactly `cfg_delay` cycles, then go to CAPTURE.
- **CAPTURE**
  - `adc_start`=1 throughout.
  - `adc_finish` sampled high: increment `acq_idx` and go to GAP.
  - Capture counter reaches `TIMEOUT` without `adc_finish`: set `err_timeout` and go to IDLE. No `done`.
- **GAP**
  - `adc_start`=0 for at least 2 cycles, so ADC capture sees a fresh rising edge on the next shot.
  - Exit when both conditions hold: 2 cycles have elapsed, and the period counter ≥ `cfg_period`−1.
  - If `cfg_period` is shorter than one shot, the exit happens after the 2-cycle minimum (no error).
  - Exit target: DONE if `acq_idx` = `cfg_num_acq`, else PULSE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **abort**
  - Any state goes to IDLE on the next edge, and `pulse_out`/`adc_start` drop on that edge.
  - `acq_idx` holds its value. No `done`.
  - Takes priority over `arm` in the same cycle.
- `arm` while `busy` is ignored.
- The period counter saturates at its all-ones value and does not wrap.
- `acq_idx` never exceeds `cfg_num_acq`.
- Reset (`reset_n`=0 on an edge): all outputs 0, state IDLE, all counters 0, `err_timeout`=0. This holds mid-burst as well.

## Timing
- All outputs are registered.
- `arm` at edge k gives `busy`=1 and `pulse_out`=1 from edge k+1.
- `pulse_out` falls at edge k+1+P, where P = max(`cfg_pulse_len`,1).
- `adc_start` rises at edge k+1+P+D, where D = `cfg_delay`.
- `adc_finish` at edge m: `adc_start`=0 and `acq_idx` incremented from edge m+1.
- Successive `pulse_out` rising edges are exactly `cfg_period` cycles apart, provided `cfg_period` ≥ P+D+(capture length)+3.
- `done` is asserted for the single cycle after the last GAP. `busy` falls on the following edge.

## Structure
- The shared package holds:
  - the state encoding enum (IDLE…DONE);
  - the default `TIMEOUT`;
  - the 8192-sample capture length, for benches that predict CAPTURE duration.
- One sub-module, `acq_down_counter`: loadable down-counter with zero flag, used for the PULSE and DELAY lengths.
- The period and timeout counters are inline.

## Test plan
- **Single shot**
  - Stimulus: `num_acq`=1, `pulse_len`=4, `delay`=10, `period`=9000; finish model replies 8192 cycles after `adc_start`.
  - Required: `pulse_out` high 4 cycles; `adc_start` rises 14 cycles after `pulse_out` rises; `done` once; `acq_idx`=1.
- **Burst**
  - Stimulus: `num_acq`=3, `period`=9000.
  - Required: `pulse_out` rising edges exactly 9000 cycles apart; 3 `adc_start` rising edges; `done` after the third `adc_finish` plus the GAP.
- **Zero / short fields**
  - Stimulus: `pulse_len`=0, `delay`=0, `period`=1.
  - Required: 1-cycle pulse; `adc_start` on the cycle after the pulse; GAP lasts exactly 2 cycles.
- **Timeout**
  - Stimulus: `adc_finish` never asserted, `TIMEOUT`=64.
  - Required: `err_timeout`=1, `busy` falls, no `done`; a new `arm` clears `err_timeout`.
- **Abort**
  - Stimulus: `abort` mid-DELAY of shot 2.
  - Required: IDLE next cycle, `adc_start` never rises for that shot, `acq_idx`=1; `arm` together with `abort` is ignored.
- **Reset and ignore rules**
  - Stimulus: `reset_n` low mid-CAPTURE.
  - Required: all outputs 0 after the edge.
  - Also: `arm` while `busy`, and `arm` with `num_acq`=0, are both ignored.
